// File: rtl/subleq_mem_arbiter.sv
// rtl/subleq_mem_arbiter.sv - round-robin arbiter sharing one SUBLEQ memory port among N_CORES cores
// Lock ownership keeps the read-B/write-B pair of one instruction atomic on the shared port.
module subleq_mem_arbiter #(
   parameter int N_CORES = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int RD_LAT  = 2
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [N_CORES-1:0]    req,
   input  logic [N_CORES-1:0]    we,
   input  logic [N_CORES-1:0]    lock,
   input  logic [N_CORES*AW-1:0] addr,
   input  logic [N_CORES*DW-1:0] wdata,
   output logic [N_CORES-1:0]    gnt,
   output logic [N_CORES-1:0]    rvalid,
   output logic [DW-1:0]         rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_din,
   input  logic [DW-1:0]         mem_dout
);

   localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   typedef logic [PW-1:0] idx_t;

   idx_t                ptr;
   idx_t                own;
   logic                own_v;
   logic [RD_LAT-1:0]   tag_v;
   idx_t [RD_LAT-1:0]   tag_c;

   logic                scan_hit;
   idx_t                scan_sel;
   logic [PW:0]         sum;
   logic                g_hit;
   idx_t                g_sel;
   idx_t                g_next;
   logic [N_CORES-1:0]  rv_next;

   // Scan starts at ptr; the extra sum bit lets the wrap be a single subtract.
   always_comb begin
      scan_hit = 1'b0;
      scan_sel = '0;
      sum      = '0;
      for (int k = 0; k < N_CORES; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N_CORES))
            sum = sum - (PW+1)'(N_CORES);
         if (!scan_hit && req[sum[PW-1:0]]) begin
            scan_hit = 1'b1;
            scan_sel = sum[PW-1:0];
         end
      end
   end

   always_comb begin
      g_hit = 1'b0;
      g_sel = '0;
      if (!rst) begin
         if (own_v) begin
            g_hit = req[own];
            g_sel = own;
         end else begin
            g_hit = scan_hit;
            g_sel = scan_sel;
         end
      end
   end

   always_comb begin
      gnt      = '0;
      mem_en   = g_hit;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (g_hit) begin
         gnt[g_sel] = 1'b1;
         mem_we     = we[g_sel];
         mem_addr   = addr[int'(g_sel)*AW +: AW];
         mem_din    = wdata[int'(g_sel)*DW +: DW];
      end
   end

   assign g_next = (g_sel == idx_t'(N_CORES-1)) ? '0 : g_sel + idx_t'(1);

   always_comb begin
      rv_next = '0;
      if (tag_v[RD_LAT-1])
         rv_next[tag_c[RD_LAT-1]] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         ptr    <= '0;
         own    <= '0;
         own_v  <= 1'b0;
         tag_v  <= '0;
         tag_c  <= '0;
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         if (g_hit) begin
            if (!own_v)
               ptr <= g_next;
            if (lock[g_sel]) begin
               own   <= g_sel;
               own_v <= 1'b1;
            end else if (own_v) begin
               own_v <= 1'b0;
            end
         end else if (own_v && !req[own] && !lock[own]) begin
            own_v <= 1'b0;
         end
         tag_v[0] <= g_hit & ~we[g_sel];
         tag_c[0] <= g_sel;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_c[i] <= tag_c[i-1];
         end
         rvalid <= rv_next;
         if (tag_v[RD_LAT-1])
            rdata <= mem_dout;
      end
   end

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// tb/tb_subleq_mem_arbiter.sv - directed table plus randomized traffic against a behavioural arbiter model
module tb_subleq_mem_arbiter;
   localparam int N      = 4;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int RD_LAT = 2;

   logic              clock;
   logic              rst;
   logic [N-1:0]      req, we, lock;
   logic [N*AW-1:0]   addr;
   logic [N*DW-1:0]   wdata;
   logic [N-1:0]      gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              mem_en, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_din, mem_dout;

   subleq_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] init_word(input int a);
      return 32'h1000_0000 + 32'(a) * 32'h11;
   endfunction

   // Memory with fixed read latency, preloaded while load is high.
   logic          load;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_pipe [RD_LAT];
   always @(posedge clock) begin
      if (load) begin
         for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_din;
      end
      rd_pipe[0] <= mem[mem_addr[7:0]];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_dout = rd_pipe[RD_LAT-1];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_g;

   // Reference model state
   int            m_ptr = 0;
   int            m_own = 0;
   bit            m_own_v = 0;
   logic [DW-1:0] shadow [256];
   logic [N-1:0]  exp_rv [int];
   logic [DW-1:0] exp_rd [int];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] rq);
      if (m_own_v) return rq[m_own] ? m_own : -1;
      for (int k = 0; k < N; k++)
         if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic do_cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] w,
                           input logic [N-1:0] lk, input logic [N*AW-1:0] ad,
                           input logic [N*DW-1:0] wd, input logic has_exp, input logic [N-1:0] eg);
      int g;
      logic [N-1:0]  gv;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ewe;
      logic [7:0]    ma;
      rst = r; req = rq; we = w; lock = lk; addr = ad; wdata = wd;
      #2;
      g  = r ? -1 : model_grant(rq);
      gv = '0; ea = '0; ed = '0; ewe = 1'b0;
      if (g >= 0) begin
         gv[g] = 1'b1;
         ea    = ad[g*AW +: AW];
         ed    = wd[g*DW +: DW];
         ewe   = w[g];
      end
      chk("gnt_model", 64'(gnt), 64'(gv));
      if (has_exp) chk("gnt_table", 64'(gnt), 64'(eg));
      chk("mem_en", 64'(mem_en), 64'(g >= 0));
      chk("mem_we", 64'(mem_we), 64'(ewe));
      chk("mem_addr", 64'(mem_addr), 64'(ea));
      chk("mem_din", 64'(mem_din), 64'(ed));
      chk("rvalid", 64'(rvalid), exp_rv.exists(cyc) ? 64'(exp_rv[cyc]) : 64'd0);
      if (exp_rv.exists(cyc)) chk("rdata", 64'(rdata), 64'(exp_rd[cyc]));
      last_g = g;
      @(posedge clock); #1;
      if (r) begin
         m_ptr = 0; m_own_v = 0;
         exp_rv.delete(); exp_rd.delete();
      end else if (g >= 0) begin
         if (!m_own_v) m_ptr = (g + 1) % N;
         if (lk[g]) begin m_own = g; m_own_v = 1; end
         else if (m_own_v) m_own_v = 0;
         ma = ad[g*AW +: 8];
         if (w[g]) shadow[ma] = wd[g*DW +: DW];
         else begin
            exp_rv[cyc + RD_LAT + 1] = gv;
            exp_rd[cyc + RD_LAT + 1] = shadow[ma];
         end
      end else if (m_own_v && !rq[m_own] && !lk[m_own]) begin
         m_own_v = 0;
      end
      cyc++;
   endtask

   typedef struct {
      logic            r;
      logic [N-1:0]    rq, w, lk;
      logic [N*AW-1:0] ad;
      logic [N*DW-1:0] wd;
      logic [N-1:0]    eg;
   } vec_t;
   vec_t tbl [$];

   function automatic logic [N*AW-1:0] pk(input logic [31:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic add(input logic r, input logic [N-1:0] rq, w, lk,
                      input logic [N*AW-1:0] ad, input logic [N*DW-1:0] wd, input logic [N-1:0] eg);
      vec_t v;
      v.r = r; v.rq = rq; v.w = w; v.lk = lk; v.ad = ad; v.wd = wd; v.eg = eg;
      tbl.push_back(v);
   endtask

   // Random-traffic core state
   bit            pend [N];
   bit            rwe [N];
   bit            rlock [N];
   bit            phase [N];
   int            gap [N];
   logic [31:0]   raddr [N];
   logic [31:0]   rwd [N];

   initial begin
      logic [N*AW-1:0] a0;
      logic [N*DW-1:0] z;
      logic [N-1:0]    rq, w, lk;
      logic [N*AW-1:0] ad;
      logic [N*DW-1:0] wd;
      a0 = pk(32'h40, 32'h41, 32'h42, 32'h43);
      z  = '0;
      for (int a = 0; a < 256; a++) shadow[a] = init_word(a);
      rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
      load = 1'b1;
      @(posedge clock); #1;

      do_cycle(1, 4'b1111, 4'b0, 4'b0, a0, z, 1, 4'b0);
      do_cycle(1, 4'b1111, 4'b0, 4'b0, a0, z, 1, 4'b0);
      load = 1'b0;
      chk("rdata_reset", 64'(rdata), 64'd0);
      chk("rvalid_reset", 64'(rvalid), 64'd0);

      for (int i = 0; i < 3; i++) add(1, 4'b1111, 4'b0, 4'b0, a0, z, 4'b0000);
      for (int i = 0; i < 8; i++) add(0, 4'b1111, 4'b0, 4'b0, a0, z, 4'(1 << (i % 4)));
      for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0, 4'b0, a0, z, 4'b0000);
      add(0, 4'b0100, 4'b0, 4'b0, a0, z, 4'b0100);
      add(0, 4'b1001, 4'b0, 4'b0, a0, z, 4'b1000);
      add(0, 4'b0001, 4'b0, 4'b0, a0, z, 4'b0001);
      add(0, 4'b1111, 4'b0, 4'b0010, pk(32'h40, 32'h10, 32'h42, 32'h43), z, 4'b0010);
      add(0, 4'b1101, 4'b0, 4'b0010, pk(32'h40, 32'h10, 32'h42, 32'h43), z, 4'b0000);
      add(0, 4'b1101, 4'b0, 4'b0010, pk(32'h40, 32'h10, 32'h42, 32'h43), z, 4'b0000);
      add(0, 4'b1111, 4'b0010, 4'b0, pk(32'h40, 32'h10, 32'h42, 32'h43),
          {32'h0, 32'h0, 32'h1234_5678, 32'h0}, 4'b0010);
      add(0, 4'b1101, 4'b0, 4'b0, a0, z, 4'b0100);
      add(0, 4'b0010, 4'b0, 4'b0, pk(32'h40, 32'h10, 32'h42, 32'h43), z, 4'b0010);
      for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0, 4'b0, a0, z, 4'b0000);
      add(0, 4'b0100, 4'b0100, 4'b0, pk(32'h40, 32'h41, 32'h20, 32'h43),
          {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}, 4'b0100);
      add(0, 4'b0001, 4'b0, 4'b0, pk(32'h20, 32'h41, 32'h42, 32'h43), z, 4'b0001);
      for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0, 4'b0, a0, z, 4'b0000);
      add(0, 4'b1000, 4'b0, 4'b0, a0, z, 4'b1000);
      add(1, 4'b0000, 4'b0, 4'b0, a0, z, 4'b0000);
      for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0, 4'b0, a0, z, 4'b0000);
      add(0, 4'b1111, 4'b0, 4'b0, a0, z, 4'b0001);
      for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0, 4'b0, a0, z, 4'b0000);

      foreach (tbl[i])
         do_cycle(tbl[i].r, tbl[i].rq, tbl[i].w, tbl[i].lk, tbl[i].ad, tbl[i].wd, 1, tbl[i].eg);

      chk("mem_0x10_written", 64'(mem[8'h10]), 64'h1234_5678);
      chk("mem_0x20_written", 64'(mem[8'h20]), 64'hDEAD_BEEF);

      for (int i = 0; i < N; i++) begin
         pend[i] = 0; rwe[i] = 0; rlock[i] = 0; phase[i] = 0; gap[i] = 0;
         raddr[i] = '0; rwd[i] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               if (phase[i]) begin
                  if (gap[i] > 0) gap[i]--;
                  else if ($urandom % 8 == 0) phase[i] = 0;
                  else begin pend[i] = 1; rwe[i] = 1; rlock[i] = 0; rwd[i] = $urandom; end
               end else if ($urandom % 3 == 0) begin
                  pend[i]  = 1;
                  rwe[i]   = ($urandom % 3 == 0);
                  rlock[i] = !rwe[i] && ($urandom % 4 == 0);
                  raddr[i] = $urandom % 64;
                  rwd[i]   = $urandom;
               end
            end
            rq[i] = pend[i];
            w[i]  = pend[i] & rwe[i];
            lk[i] = pend[i] ? rlock[i] : phase[i];
            ad[i*AW +: AW] = raddr[i];
            wd[i*DW +: DW] = rwd[i];
         end
         do_cycle(($urandom % 100) == 0, rq, w, lk, ad, wd, 0, 4'b0);
         if (last_g >= 0) begin
            pend[last_g] = 0;
            if (phase[last_g] && rwe[last_g]) phase[last_g] = 0;
            else if (rlock[last_g]) begin phase[last_g] = 1; gap[last_g] = $urandom % 3; end
         end
      end
      for (int i = 0; i < RD_LAT + 2; i++) do_cycle(0, 4'b0, 4'b0, 4'b0, a0, z, 1, 4'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
